// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the front end of the CPU: the fetch FSM state
// encoding, the default reset PC and the canonical NOP instruction word.
// No ports; imported by fetch_unit and pc_reg.
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Default architectural width for addresses and instruction words.
    localparam int XLEN_DEFAULT = 32;

    // PC loaded when the core comes out of reset.
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    // addi x0, x0, 0 -- used wherever a harmless filler instruction is needed.
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Fetch FSM states:
    //   S_REQ   - request presented to instruction memory
    //   S_WAIT  - request accepted, waiting for the instruction word
    //   S_HOLD  - instruction buffered, waiting for downstream to take it
    //   S_DRAIN - a killed request is still outstanding; swallow its response
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Architectural program-counter register with load and increment enables
// plus the PC+4 adder shared with the next-PC select logic.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset, loads PC_RESET
//   load_i     in   load load_pc_i into the PC (wins over inc_i)
//   load_pc_i  in   value to load
//   inc_i      in   advance the PC by 4
//   pc_o       out  current PC
//   pc_add4_o  out  current PC + 4, wraps modulo 2^XLEN
// ---------------------------------------------------------------------------
module pc_reg
    import cpu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic            inc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_add4_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pcAdd4;

    // The adder simply drops the carry out, so the top word wraps to zero.
    assign pcAdd4 = pc_q + XLEN'(4);

    // A load always beats an increment: a redirect arriving in the same
    // cycle the current instruction retires must not be offset by 4.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i;
        end else if (inc_i) begin
            pc_d = pcAdd4;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pc_add4_o = pcAdd4;

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// PC and instruction-fetch stage. Issues one instruction-memory request at a
// time, buffers the returned word together with its PC and hands it
// downstream. Redirects reload the PC and kill any stale in-flight fetch.
//
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   synchronous active-high reset
//   redirect_valid   in   taken jump/branch: load redirect_pc
//   redirect_pc      in   redirect target (low two bits ignored)
//   imem_req_valid   out  fetch request valid (registered)
//   imem_req_ready   in   memory accepts the request
//   imem_addr        out  fetch address, always the current PC
//   imem_resp_valid  in   instruction word valid, one per accepted request
//   imem_resp_data   in   instruction word
//   if_valid         out  buffered instruction available (registered)
//   if_ready         in   downstream consumes the instruction
//   if_pc            out  PC of the buffered instruction (registered)
//   if_inst          out  buffered instruction (registered)
//   pc_add4          out  current PC + 4 for the next-PC select stage
// ---------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_inst,
    output logic [XLEN-1:0] pc_add4
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic            reqValid_q;
    logic            reqValid_d;
    logic            ifValid_q;
    logic            ifValid_d;
    logic [XLEN-1:0] ifPc_q;
    logic [XLEN-1:0] ifInst_q;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirectAligned;
    logic            handshake;
    logic            latchResp;
    logic            consume;
    logic            incPc;

    // Redirect targets are forced word aligned before they reach the PC.
    assign redirectAligned = {redirect_pc[XLEN-1:2], 2'b00};

    // The request is only "seen" by memory when our registered valid is up,
    // so the handshake is qualified by the register, not by the state.
    assign handshake = reqValid_q & imem_req_ready;

    // A response is captured only when it belongs to a live fetch.
    assign latchResp = (state_q == S_WAIT) & imem_resp_valid & ~redirect_valid;

    // Downstream takes the buffered word; a same-cycle redirect drops it
    // instead, so no PC increment happens in that case.
    assign consume = (state_q == S_HOLD) & if_ready;
    assign incPc   = consume & ~redirect_valid;

    pc_reg #(
        .XLEN     (XLEN),
        .PC_RESET (PC_RESET)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (redirect_valid),
        .load_pc_i (redirectAligned),
        .inc_i     (incPc),
        .pc_o      (pc),
        .pc_add4_o (pc_add4)
    );

    // Next-state logic. A redirect takes precedence everywhere: if a request
    // has already been accepted (or is accepted this very cycle) and its
    // response has not yet shown up, we must go swallow it in S_DRAIN;
    // otherwise we can go straight back to requesting the new PC.
    // In S_DRAIN the arriving response always ends the drain, even when a
    // further redirect lands in the same cycle -- staying would wait for a
    // response that will never come.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    state_d = handshake ? S_DRAIN : S_REQ;
                end else if (handshake) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d = redirect_valid ? S_REQ : S_HOLD;
                end else if (redirect_valid) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redirect_valid || if_ready) begin
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // The request valid is registered and follows the next state, so it is
    // high exactly in the cycles where the FSM sits in S_REQ (apart from the
    // first cycle after reset, where it is still low).
    assign reqValid_d = (state_d == S_REQ);

    // Output buffer valid: cleared by a redirect or by consumption, set when
    // a live response is captured.
    always_comb begin
        ifValid_d = ifValid_q;
        if (redirect_valid) begin
            ifValid_d = 1'b0;
        end else if (latchResp) begin
            ifValid_d = 1'b1;
        end else if (consume) begin
            ifValid_d = 1'b0;
        end
    end

    // FSM, request valid and instruction buffer registers. Resetting puts
    // the FSM back in S_REQ, which ignores any response left over from
    // before the reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            reqValid_q <= 1'b0;
            ifValid_q  <= 1'b0;
            ifPc_q     <= '0;
            ifInst_q   <= '0;
        end else begin
            state_q    <= state_d;
            reqValid_q <= reqValid_d;
            ifValid_q  <= ifValid_d;
            if (latchResp) begin
                ifPc_q   <= pc;
                ifInst_q <= imem_resp_data;
            end
        end
    end

    assign imem_req_valid = reqValid_q;
    assign imem_addr      = pc;
    assign if_valid       = ifValid_q;
    assign if_pc          = ifPc_q;
    assign if_inst        = ifInst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed self-checking bench for fetch_unit. Inputs change 1 time unit
// after a rising edge and outputs are checked at the same point, well away
// from the next active edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] pc_add4;

    int assertCount = 0;
    int failCount   = 0;

    fetch_unit #(
        .PC_RESET (32'h0000_3000),
        .XLEN     (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .pc_add4         (pc_add4)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive every DUT input at once.
    task automatic applyStimulus(input logic rstV, input logic redirV,
                                 input logic [31:0] redirPc, input logic reqReady,
                                 input logic respV, input logic [31:0] respData,
                                 input logic ifReady);
        rst             = rstV;
        redirect_valid  = redirV;
        redirect_pc     = redirPc;
        imem_req_ready  = reqReady;
        imem_resp_valid = respV;
        imem_resp_data  = respData;
        if_ready        = ifReady;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One comparison point.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // From S_REQ at addr: handshake, return data the next cycle, and check the
    // word is buffered with its PC. Leaves the DUT holding the instruction.
    task automatic fetchToHold(input string tag, input logic [31:0] addr,
                               input logic [31:0] data);
        checkOutput({tag, "_reqValid"}, {31'b0, imem_req_valid}, 32'd1);
        checkOutput({tag, "_addr"}, imem_addr, addr);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        checkOutput({tag, "_waitReqValid"}, {31'b0, imem_req_valid}, 32'd0);
        checkOutput({tag, "_waitIfValid"}, {31'b0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, data, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput({tag, "_ifValid"}, {31'b0, if_valid}, 32'd1);
        checkOutput({tag, "_ifPc"}, if_pc, addr);
        checkOutput({tag, "_ifInst"}, if_inst, data);
    endtask

    // Consume the held instruction and check the next request is at nextAddr.
    task automatic consume(input string tag, input logic [31:0] nextAddr);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput({tag, "_consumedIfValid"}, {31'b0, if_valid}, 32'd0);
        checkOutput({tag, "_nextReqValid"}, {31'b0, imem_req_valid}, 32'd1);
        checkOutput({tag, "_nextAddr"}, imem_addr, nextAddr);
    endtask

    initial begin
        $display("[TB] fetch_unit directed test start");

        // Reset state.
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        step();
        checkOutput("rst_ifValid", {31'b0, if_valid}, 32'd0);
        checkOutput("rst_ifPc", if_pc, 32'h0);
        checkOutput("rst_ifInst", if_inst, 32'h0);
        checkOutput("rst_reqValid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'h0000_3000);
        checkOutput("rst_pcAdd4", pc_add4, 32'h0000_3004);

        // Release reset; the request goes up one cycle later.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();

        // Straight-line fetch of three instructions, 3 cycles each.
        fetchToHold("seq0", 32'h0000_3000, 32'h0010_0093);
        consume("seq0", 32'h0000_3004);
        fetchToHold("seq1", 32'h0000_3004, 32'h0020_0113);
        consume("seq1", 32'h0000_3008);
        fetchToHold("seq2", 32'h0000_3008, 32'h0030_0193);
        consume("seq2", 32'h0000_300C);

        // Backpressure: buffer held for 5 cycles with no new request.
        fetchToHold("bp", 32'h0000_300C, 32'h0050_0093);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("bp_ifValid", {31'b0, if_valid}, 32'd1);
            checkOutput("bp_ifPc", if_pc, 32'h0000_300C);
            checkOutput("bp_ifInst", if_inst, 32'h0050_0093);
            checkOutput("bp_reqValid", {31'b0, imem_req_valid}, 32'd0);
            checkOutput("bp_pc", imem_addr, 32'h0000_300C);
        end
        consume("bp", 32'h0000_3010);

        // Redirect while the response for 0x3010 is still pending.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b1, 32'h0000_3100, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        checkOutput("rw_drainReqValid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rw_drainAddr", imem_addr, 32'h0000_3100);
        checkOutput("rw_drainIfValid", {31'b0, if_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        checkOutput("rw_staleIfValid", {31'b0, if_valid}, 32'd0);
        checkOutput("rw_staleIfInst", if_inst, 32'h0050_0093);
        fetchToHold("rw", 32'h0000_3100, 32'h0060_0093);

        // Redirect in S_HOLD together with if_ready: no +4, misaligned target.
        applyStimulus(1'b0, 1'b1, 32'h0000_3203, 1'b0, 1'b0, 32'h0, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rh_ifValid", {31'b0, if_valid}, 32'd0);
        checkOutput("rh_reqValid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("rh_addr", imem_addr, 32'h0000_3200);

        // Redirect in S_REQ without handshake to the top word, then wrap.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("wrap_pcAdd4", pc_add4, 32'h0000_0000);
        fetchToHold("wrap", 32'hFFFF_FFFC, 32'h0070_0093);
        consume("wrap", 32'h0000_0000);

        // Reset while in S_WAIT; the late response must be ignored.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        checkOutput("rs_ifValid", {31'b0, if_valid}, 32'd0);
        checkOutput("rs_addr", imem_addr, 32'h0000_3000);
        checkOutput("rs_reqValid", {31'b0, imem_req_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("rs_lateIfValid", {31'b0, if_valid}, 32'd0);
        checkOutput("rs_lateIfInst", if_inst, 32'h0);
        fetchToHold("rs", 32'h0000_3000, 32'h0080_0093);
        consume("rs", 32'h0000_3004);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
